// File: rtl/munoc_interval_timer.sv
// Interval timer: counts down a loaded number of ticks, where one tick is
// TICK_PERIOD clock cycles. Supports one-shot and periodic (auto-reload)
// operation, counts expiries, and flags rejected start commands.
module munoc_interval_timer #(
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned TICK_PERIOD  = 500,
  parameter int unsigned EXPIRE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    cmd_valid,
  input  logic                    cmd_start,
  input  logic [COUNT_WIDTH-1:0]  load_value,
  input  logic                    periodic,
  output logic                    running,
  output logic [COUNT_WIDTH-1:0]  remaining,
  output logic                    expire_pulse,
  output logic [EXPIRE_WIDTH-1:0] expire_count,
  output logic                    cmd_error
);

  localparam int unsigned PrescWidth = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [PrescWidth-1:0] TickLast = PrescWidth'(TICK_PERIOD - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q;
  logic [PrescWidth-1:0]    presc_q;
  logic [COUNT_WIDTH-1:0]   reload_q;
  logic                     periodic_q;

  logic start_cmd;
  logic stop_cmd;
  logic tick;

  // Command and tick decode; commands take precedence over the tick below.
  always_comb begin
    start_cmd = cmd_valid && cmd_start;
    stop_cmd  = cmd_valid && !cmd_start;
    tick      = (state_q == StRun) && (presc_q == TickLast);
  end

  // Running flag is a direct view of the state flop.
  always_comb begin
    running = (state_q == StRun);
  end

  // Timer state machine with registered outputs.
  always_ff @(posedge clk) begin
    // Pulses default low and are only raised for a single cycle.
    expire_pulse <= 1'b0;
    cmd_error    <= 1'b0;
    if (rst || clear) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      remaining    <= '0;
      expire_count <= '0;
      reload_q     <= '0;
      periodic_q   <= 1'b0;
    end else if (start_cmd) begin
      if (load_value != '0) begin
        // A restart discards any countdown in flight, including one that
        // would have expired on this very tick.
        state_q    <= StRun;
        presc_q    <= '0;
        remaining  <= load_value;
        reload_q   <= load_value;
        periodic_q <= periodic;
      end else begin
        // Rejected start freezes the timer for this cycle.
        cmd_error <= 1'b1;
      end
    end else if (stop_cmd) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      remaining <= '0;
    end else if (state_q == StRun) begin
      if (tick) begin
        presc_q <= '0;
        if (remaining > COUNT_WIDTH'(1)) begin
          remaining <= remaining - COUNT_WIDTH'(1);
        end else begin
          expire_pulse <= 1'b1;
          expire_count <= expire_count + EXPIRE_WIDTH'(1);
          if (periodic_q) begin
            remaining <= reload_q;
          end else begin
            state_q   <= StIdle;
            remaining <= '0;
          end
        end
      end else begin
        presc_q <= presc_q + PrescWidth'(1);
      end
    end else begin
      presc_q <= '0;
    end
  end

endmodule
